cpu_issue_ctrl: RTL and testbench

- Issue/hazard controller between the instruction FIFO and the decode/execute stage.
- Accepts {opcode, operand} words, works out each instruction's register read/write sets from the moxie encoding, and keeps a 16-entry register scoreboard.
- Holds an instruction while a RAW/WAW hazard exists. Issues to execute through a registered valid/ready port.
- Scoreboard bits clear on writeback; pending work is dropped on branch flush.

---
 rtl/cpu_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_cpu_issue_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_issue_ctrl.sv
// Issue/hazard controller: decodes moxie register read/write sets, tracks a 16-entry
// write scoreboard, holds hazarded instructions in H and issues through registered O.
module cpu_issue_ctrl #(
  parameter int STALL_CNT_W   = 16,
  parameter bit SERIALIZE_DIV = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [15:0]            opcode_i,
  input  logic [31:0]            operand_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   iss_valid_o,
  input  logic                   iss_ready_i,
  output logic [15:0]            iss_opcode_o,
  output logic [31:0]            iss_operand_o,
  output logic [15:0]            iss_wr_mask_o,
  input  logic                   wb_valid_i,
  input  logic [15:0]            wb_mask_i,
  input  logic                   flush_i,
  output logic                   sb_busy_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic [15:0] rd;
    logic [15:0] wr;
    logic        isdiv;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] op);
    dec_t        d;
    logic [15:0] ma;
    logic [15:0] mb;
    logic [15:0] mc;
    ma = 16'd1 << op[7:4];
    mb = 16'd1 << op[3:0];
    mc = 16'd1 << op[11:8];
    d  = '0;
    // 0x80-0x9F are the inc/dec forms with the register in op[11:8]
    if (op[15:13] == 3'b100) begin
      d.rd = mc;
      d.wr = mc;
    end else begin
      case (op[15:8])
        8'h05, 8'h06, 8'h26, 8'h27, 8'h28, 8'h29, 8'h2B, 8'h2D, 8'h2E, 8'h2F,
        8'h31, 8'h32, 8'h33, 8'h34: begin d.rd = ma | mb; d.wr = ma; end
        8'h02, 8'h0A, 8'h1C, 8'h21, 8'h2A, 8'h2C: begin d.rd = mb; d.wr = ma; end
        8'h01, 8'h08, 8'h1B, 8'h1D, 8'h20, 8'h22: d.wr = ma;
        8'h0B, 8'h0E, 8'h1E, 8'h23: d.rd = ma | mb;
        8'h09, 8'h19, 8'h1F, 8'h24, 8'h25: d.rd = ma;
        8'h07: begin d.rd = ma; d.wr = ma | mb; end
        default: ;
      endcase
    end
    d.isdiv = (op[15:8] >= 8'h31) && (op[15:8] <= 8'h34);
    return d;
  endfunction

  logic                   h_vld_q, h_vld_d, o_vld_q, o_vld_d;
  logic [15:0]            h_op_q, h_op_d, o_op_q, o_op_d, o_wr_q, o_wr_d;
  logic [31:0]            h_opd_q, h_opd_d, o_opd_q, o_opd_d;
  logic [15:0]            sb_q, sb_d;
  logic                   sb_busy_q;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  dec_t                   h_dec;
  logic [15:0]            wb_clr, flush_clr, sb_eff;
  logic                   hazard, move, accept;

  assign h_dec     = decode(h_op_q);
  assign wb_clr    = wb_valid_i ? wb_mask_i : 16'h0;
  // A writeback landing this cycle already satisfies the dependency
  assign sb_eff    = sb_q & ~wb_clr;
  assign hazard    = h_vld_q & ((((h_dec.rd | h_dec.wr) & sb_eff) != 16'h0) |
                                (SERIALIZE_DIV & h_dec.isdiv & (sb_eff != 16'h0)));
  assign move      = h_vld_q & ~hazard & (~o_vld_q | iss_ready_i) & ~flush_i;
  assign ready_o   = ~rst_i & ~flush_i & (~h_vld_q | move);
  assign accept    = valid_i & ready_o;
  assign flush_clr = (flush_i & o_vld_q & ~iss_ready_i) ? o_wr_q : 16'h0;

  always_comb begin
    h_vld_d = h_vld_q;
    h_op_d  = h_op_q;
    h_opd_d = h_opd_q;
    o_vld_d = o_vld_q;
    o_op_d  = o_op_q;
    o_opd_d = o_opd_q;
    o_wr_d  = o_wr_q;
    if (flush_i) begin
      h_vld_d = 1'b0;
      o_vld_d = 1'b0;
    end else begin
      if (accept) begin
        h_vld_d = 1'b1;
        h_op_d  = opcode_i;
        h_opd_d = operand_i;
      end else if (move) begin
        h_vld_d = 1'b0;
      end
      if (move) begin
        o_vld_d = 1'b1;
        o_op_d  = h_op_q;
        o_opd_d = h_opd_q;
        o_wr_d  = h_dec.wr;
      end else if (iss_ready_i) begin
        o_vld_d = 1'b0;
      end
    end
    sb_d    = (sb_q & ~wb_clr & ~flush_clr) | (move ? h_dec.wr : 16'h0);
    stall_d = stall_q;
    if (hazard & ~flush_i & ~(&stall_q))
      stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_vld_q   <= 1'b0;
      h_op_q    <= 16'h0;
      h_opd_q   <= 32'h0;
      o_vld_q   <= 1'b0;
      o_op_q    <= 16'h0;
      o_opd_q   <= 32'h0;
      o_wr_q    <= 16'h0;
      sb_q      <= 16'h0;
      sb_busy_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      h_vld_q   <= h_vld_d;
      h_op_q    <= h_op_d;
      h_opd_q   <= h_opd_d;
      o_vld_q   <= o_vld_d;
      o_op_q    <= o_op_d;
      o_opd_q   <= o_opd_d;
      o_wr_q    <= o_wr_d;
      sb_q      <= sb_d;
      sb_busy_q <= |sb_d;
      stall_q   <= stall_d;
    end
  end

  assign iss_valid_o   = o_vld_q;
  assign iss_opcode_o  = o_op_q;
  assign iss_operand_o = o_opd_q;
  assign iss_wr_mask_o = o_wr_q;
  assign sb_busy_o     = sb_busy_q;
  assign stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_cpu_issue_ctrl.sv
// Bench for cpu_issue_ctrl: default instance plus a STALL_CNT_W=4 / SERIALIZE_DIV=0
// instance sharing the same stimulus; issued words are checked against a queue.
module tb_cpu_issue_ctrl;

  typedef struct packed {
    logic [15:0] op;
    logic [31:0] opd;
    logic [15:0] wr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, valid, iss_ready, wb_valid, flush;
  logic [15:0] opcode, wb_mask;
  logic [31:0] operand;
  logic        ready, iss_valid, sb_busy;
  logic [15:0] iss_opcode, iss_wr_mask, stall_cnt;
  logic [31:0] iss_operand;
  logic        b_ready, b_iss_valid, b_sb_busy;
  logic [15:0] b_iss_opcode, b_iss_wr_mask;
  logic [31:0] b_iss_operand;
  logic [3:0]  b_stall_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cpu_issue_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .operand_i(operand), .valid_i(valid),
    .ready_o(ready), .iss_valid_o(iss_valid), .iss_ready_i(iss_ready),
    .iss_opcode_o(iss_opcode), .iss_operand_o(iss_operand), .iss_wr_mask_o(iss_wr_mask),
    .wb_valid_i(wb_valid), .wb_mask_i(wb_mask), .flush_i(flush),
    .sb_busy_o(sb_busy), .stall_cnt_o(stall_cnt)
  );

  cpu_issue_ctrl #(.STALL_CNT_W(4), .SERIALIZE_DIV(1'b0)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .operand_i(operand), .valid_i(valid),
    .ready_o(b_ready), .iss_valid_o(b_iss_valid), .iss_ready_i(iss_ready),
    .iss_opcode_o(b_iss_opcode), .iss_operand_o(b_iss_operand), .iss_wr_mask_o(b_iss_wr_mask),
    .wb_valid_i(wb_valid), .wb_mask_i(wb_mask), .flush_i(flush),
    .sb_busy_o(b_sb_busy), .stall_cnt_o(b_stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_mask = 16'h0;
    iss_ready = 1'b1; opcode = 16'h0; operand = 32'h0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; opcode = 16'h0120; operand = 32'h0;
    iss_ready = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_mask = 16'h0;
    tick(); #1;
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL rst_iss_valid got %b want 0", iss_valid); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", ready); end
    n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL rst_b_ready got %b want 0", b_ready); end
    n_cmp++; if (sb_busy !== 1'b0) begin n_bad++; $display("FAIL rst_sb_busy got %b want 0", sb_busy); end
    n_cmp++; if (stall_cnt !== 16'h0) begin n_bad++; $display("FAIL rst_stall got %0d want 0", stall_cnt); end
    n_cmp++; if ({iss_opcode, iss_operand, iss_wr_mask} !== 64'h0) begin n_bad++; $display("FAIL rst_iss_dat got %h want 0", {iss_opcode, iss_operand, iss_wr_mask}); end
    rst = 1'b0; valid = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got %b want 1", ready); end
  endtask

  task automatic test_indep();
    exp_t e;
    do_reset();
    opcode = 16'h0120; operand = 32'h1111_0000; valid = 1'b1;
    exp_q.push_back({16'h0120, 32'h1111_0000, 16'h0004});
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL indep_ready got %b want 1", ready); end
    tick();
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL indep_latency got %b want 0", iss_valid); end
    opcode = 16'h0130; operand = 32'h2222_0000;
    exp_q.push_back({16'h0130, 32'h2222_0000, 16'h0008});
    tick();
    valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (iss_valid !== 1'b1) begin n_bad++; $display("FAIL indep_first_vld got %b want 1", iss_valid); end
    n_cmp++; if ({iss_opcode, iss_operand, iss_wr_mask} !== e) begin n_bad++; $display("FAIL indep_first got %h want %h", {iss_opcode, iss_operand, iss_wr_mask}, e); end
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (iss_valid !== 1'b1) begin n_bad++; $display("FAIL indep_second_vld got %b want 1", iss_valid); end
    n_cmp++; if ({iss_opcode, iss_operand, iss_wr_mask} !== e) begin n_bad++; $display("FAIL indep_second got %h want %h", {iss_opcode, iss_operand, iss_wr_mask}, e); end
    n_cmp++; if (sb_busy !== 1'b1) begin n_bad++; $display("FAIL indep_sb_busy got %b want 1", sb_busy); end
    wb_valid = 1'b1; wb_mask = 16'h000C;
    tick();
    wb_valid = 1'b0;
    n_cmp++; if (sb_busy !== 1'b0) begin n_bad++; $display("FAIL indep_sb_clear got %b want 0", sb_busy); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL indep_drain got %b want 0", iss_valid); end
  endtask

  task automatic test_raw();
    exp_t e;
    do_reset();
    opcode = 16'h0120; operand = 32'hA0; valid = 1'b1;
    exp_q.push_back({16'h0120, 32'hA0, 16'h0004});
    tick();
    opcode = 16'h0532; operand = 32'hA1;
    exp_q.push_back({16'h0532, 32'hA1, 16'h0008});
    tick();
    valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if ({iss_valid, iss_opcode, iss_operand, iss_wr_mask} !== {1'b1, e}) begin n_bad++; $display("FAIL raw_ldi got %h want %h", {iss_valid, iss_opcode, iss_operand, iss_wr_mask}, {1'b1, e}); end
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL raw_ready got %b want 0", ready); end
    tick();
    tick();
    n_cmp++; if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL raw_stall got %0d want 2", stall_cnt); end
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL raw_held got %b want 0", iss_valid); end
    wb_valid = 1'b1; wb_mask = 16'h0004;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL raw_bypass_ready got %b want 1", ready); end
    tick();
    wb_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if ({iss_valid, iss_opcode, iss_operand, iss_wr_mask} !== {1'b1, e}) begin n_bad++; $display("FAIL raw_add got %h want %h", {iss_valid, iss_opcode, iss_operand, iss_wr_mask}, {1'b1, e}); end
    n_cmp++; if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL raw_stall_frozen got %0d want 2", stall_cnt); end
  endtask

  task automatic test_waw_pop();
    exp_t e;
    do_reset();
    opcode = 16'h0714; operand = 32'hB0; valid = 1'b1;
    exp_q.push_back({16'h0714, 32'hB0, 16'h0012});
    tick();
    opcode = 16'h0140; operand = 32'hB1;
    exp_q.push_back({16'h0140, 32'hB1, 16'h0010});
    tick();
    valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if ({iss_valid, iss_opcode, iss_operand, iss_wr_mask} !== {1'b1, e}) begin n_bad++; $display("FAIL waw_pop got %h want %h", {iss_valid, iss_opcode, iss_operand, iss_wr_mask}, {1'b1, e}); end
    tick();
    n_cmp++; if ({iss_valid, sb_busy} !== 2'b01) begin n_bad++; $display("FAIL waw_stall got %b want 01", {iss_valid, sb_busy}); end
    wb_valid = 1'b1; wb_mask = 16'h0002;
    tick();
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL waw_partial_wb got %b want 0", iss_valid); end
    wb_mask = 16'h0010;
    tick();
    wb_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if ({iss_valid, iss_opcode, iss_operand, iss_wr_mask} !== {1'b1, e}) begin n_bad++; $display("FAIL waw_ldi got %h want %h", {iss_valid, iss_opcode, iss_operand, iss_wr_mask}, {1'b1, e}); end
  endtask

  task automatic test_flush();
    exp_t e;
    do_reset();
    iss_ready = 1'b0;
    opcode = 16'h0150; operand = 32'hC0; valid = 1'b1;
    exp_q.push_back({16'h0150, 32'hC0, 16'h0020});
    tick();
    opcode = 16'h0223; operand = 32'hC1;
    tick();
    valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if ({iss_valid, iss_opcode, iss_operand, iss_wr_mask} !== {1'b1, e}) begin n_bad++; $display("FAIL flush_o got %h want %h", {iss_valid, iss_opcode, iss_operand, iss_wr_mask}, {1'b1, e}); end
    tick();
    n_cmp++; if ({iss_valid, iss_opcode, iss_operand, iss_wr_mask} !== {1'b1, e}) begin n_bad++; $display("FAIL flush_hold got %h want %h", {iss_valid, iss_opcode, iss_operand, iss_wr_mask}, {1'b1, e}); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL flush_bp_ready got %b want 0", ready); end
    flush = 1'b1; opcode = 16'h0160; operand = 32'hC2; valid = 1'b1;
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got %b want 0", ready); end
    tick();
    flush = 1'b0;
    n_cmp++; if ({iss_valid, sb_busy} !== 2'b00) begin n_bad++; $display("FAIL flush_clear got %b want 00", {iss_valid, sb_busy}); end
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL flush_next_ready got %b want 1", ready); end
    exp_q.push_back({16'h0160, 32'hC2, 16'h0040});
    iss_ready = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    e = exp_q.pop_front();
    n_cmp++; if ({iss_valid, iss_opcode, iss_operand, iss_wr_mask} !== {1'b1, e}) begin n_bad++; $display("FAIL flush_next got %h want %h", {iss_valid, iss_opcode, iss_operand, iss_wr_mask}, {1'b1, e}); end
  endtask

  task automatic test_div();
    exp_t e;
    do_reset();
    opcode = 16'h8701; operand = 32'hD0; valid = 1'b1;
    exp_q.push_back({16'h8701, 32'hD0, 16'h0080});
    tick();
    opcode = 16'h3123; operand = 32'hD1;
    exp_q.push_back({16'h3123, 32'hD1, 16'h0004});
    tick();
    valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if ({iss_valid, iss_opcode, iss_operand, iss_wr_mask} !== {1'b1, e}) begin n_bad++; $display("FAIL div_inc got %h want %h", {iss_valid, iss_opcode, iss_operand, iss_wr_mask}, {1'b1, e}); end
    n_cmp++; if (b_iss_opcode !== 16'h8701) begin n_bad++; $display("FAIL div_b_inc got %h want 8701", b_iss_opcode); end
    tick();
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL div_serial_hold got %b want 0", iss_valid); end
    n_cmp++; if ({b_iss_valid, b_iss_opcode, b_iss_operand, b_iss_wr_mask} !== {1'b1, 16'h3123, 32'hD1, 16'h0004}) begin n_bad++; $display("FAIL div_noserial got %h want 13123000000d10004", {b_iss_valid, b_iss_opcode, b_iss_operand, b_iss_wr_mask}); end
    wb_valid = 1'b1; wb_mask = 16'h0080;
    tick();
    wb_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if ({iss_valid, iss_opcode, iss_operand, iss_wr_mask} !== {1'b1, e}) begin n_bad++; $display("FAIL div_issue got %h want %h", {iss_valid, iss_opcode, iss_operand, iss_wr_mask}, {1'b1, e}); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_bad++; $display("FAIL div_stall got %0d want 1", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    valid = 1'b1;
    for (int n = 0; n < 16; n++) begin
      opcode = 16'h0100 | 16'(n << 4); operand = 32'(n);
      tick();
    end
    opcode = 16'h0120;
    tick();
    valid = 1'b0;
    repeat (20) tick();
    n_cmp++; if (stall_cnt !== 16'd20) begin n_bad++; $display("FAIL mid_stall got %0d want 20", stall_cnt); end
    n_cmp++; if (b_stall_cnt !== 4'd15) begin n_bad++; $display("FAIL mid_stall_sat got %0d want 15", b_stall_cnt); end
    n_cmp++; if ({sb_busy, b_sb_busy, ready} !== 3'b110) begin n_bad++; $display("FAIL mid_busy got %b want 110", {sb_busy, b_sb_busy, ready}); end
    valid = 1'b1; opcode = 16'h0130; operand = 32'hE0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({iss_valid, iss_opcode, iss_operand, iss_wr_mask} !== 65'h0) begin n_bad++; $display("FAIL mid_iss got %h want 0", {iss_valid, iss_opcode, iss_operand, iss_wr_mask}); end
    n_cmp++; if ({sb_busy, ready, stall_cnt, b_stall_cnt} !== 22'h0) begin n_bad++; $display("FAIL mid_state got %h want 0", {sb_busy, ready, stall_cnt, b_stall_cnt}); end
    tick();
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready_held got %b want 0", ready); end
    rst = 1'b0;
    exp_q.push_back({16'h0130, 32'hE0, 16'h0008});
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL mid_release_ready got %b want 1", ready); end
    tick();
    valid = 1'b0;
    n_cmp++; if (iss_valid !== 1'b0) begin n_bad++; $display("FAIL mid_first_latency got %b want 0", iss_valid); end
    tick();
    e = exp_q.pop_front();
    n_cmp++; if ({iss_valid, iss_opcode, iss_operand, iss_wr_mask} !== {1'b1, e}) begin n_bad++; $display("FAIL mid_first got %h want %h", {iss_valid, iss_opcode, iss_operand, iss_wr_mask}, {1'b1, e}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_indep();
    test_raw();
    test_waw_pop();
    test_flush();
    test_div();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
